req_encoder_8to3: RTL and testbench

//  Inverse of the register-file 3-to-8 write decoder: collects up to 8 one-hot

---
 rtl/req_enc_pkg.sv | 15 +
 rtl/prio_enc8.sv | 36 +++
 rtl/req_encoder_8to3.sv | 94 +++++++++
 tb/tb_req_encoder_8to3.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// Shared sizes and helpers for the 8-to-3 request encoder.
//   N_REQ    : number of request lines (fixed at 8)
//   IDX_W    : index width, clog2(N_REQ)
//   onehot8  : index -> one-hot request mask
package req_enc_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  // One-hot mask with only bit 'idx' set.
  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder with a movable search start.
// The search begins at 'start' and walks upward, wrapping 7 -> 0; the first
// set bit found wins. With start tied to 0 this is plain fixed priority
// (bit 0 highest).
//   vec   in  8  candidate bits
//   start in  3  first position searched
//   any   out 1  at least one bit of vec is set
//   idx   out 3  position of the winning bit (0 when vec is empty)
module prio_enc8
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Wrapping scan from 'start'; 3-bit addition provides the wrap for free.
  always_comb begin
    any   = |vec;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = start + IDX_W'(i);
      if (!found && vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder_8to3.sv
// Collects up to 8 request/event lines into a pending register and hands
// them to a consumer one at a time as a registered 3-bit index with a
// valid/ready handshake. A request for a bit that is already pending sets
// a sticky overrun flag.
// Build option: define REQ_ENC_ROUND_ROBIN_EN for round-robin selection
// (search starts one past the last granted index); otherwise bit 0 has
// fixed highest priority.
//   clk      in   1  clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   en       in   1  capture enable for req
//   req      in   8  request lines, bit i requests index i
//   ready    in   1  consumer accepts idx when valid & ready
//   valid    out  1  idx holds a pending request
//   idx      out  3  index of the presented request
//   overrun  out  1  sticky: request arrived for an already-pending bit
module req_encoder_8to3
  import req_enc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic             overrun
);

  logic [N_REQ-1:0] pending;
  logic             grant_c;
  logic [N_REQ-1:0] clr_c;
  logic [N_REQ-1:0] cap_c;
  logic [N_REQ-1:0] cand_c;
  logic [IDX_W-1:0] start_c;
  logic             enc_any_c;
  logic [IDX_W-1:0] enc_idx_c;

  // Handshake and pending-set bookkeeping for the current edge.
  always_comb begin
    grant_c = valid & ready;
    clr_c   = grant_c ? onehot8(idx) : '0;
    cap_c   = en ? req : '0;
    // Same-cycle captures are excluded so a fresh request is only offered
    // after it has landed in the pending register.
    cand_c  = pending & ~clr_c;
  end

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  // Next search starts one past the index just accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_c) begin
      rr_ptr <= idx + IDX_W'(1);
    end
  end

  assign start_c = rr_ptr;
`else
  assign start_c = '0;
`endif

  prio_enc8 u_prio_enc8 (
    .vec   (cand_c),
    .start (start_c),
    .any   (enc_any_c),
    .idx   (enc_idx_c)
  );

  // Pending register: new captures win over the grant clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= cand_c | cap_c;
      overrun <= overrun | (|(cap_c & cand_c));
    end
  end

  // Output stage: reload when empty or when the consumer takes the current index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      idx   <= '0;
    end else if (!valid || ready) begin
      valid <= enc_any_c;
      idx   <= enc_idx_c;
    end
  end

endmodule

// File: tb/tb_req_encoder_8to3.sv
module tb_req_encoder_8to3;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] idx;
  logic       overrun;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       rst_first;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[$];

  req_encoder_8to3 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .req     (req),
    .ready   (ready),
    .valid   (valid),
    .idx     (idx),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pulse reset across two edges and release it away from the clock edge.
  task automatic do_reset();
    en      = 1'b0;
    req     = 8'h00;
    ready   = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic e, input logic [7:0] r, input logic rdy);
    en    = e;
    req   = r;
    ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [2:0] i, input logic o);
    check({name, " valid"}, 8'(valid), 8'(v));
    check({name, " idx"}, 8'(idx), 8'(i));
    check({name, " overrun"}, 8'(overrun), 8'(o));
  endtask

  task automatic add(input logic rf, input logic e, input logic [7:0] r, input logic rdy,
                     input logic v, input logic [2:0] i, input logic o);
    vec_t t;
    t.rst_first = rf;
    t.en        = e;
    t.req       = r;
    t.ready     = rdy;
    t.exp_valid = v;
    t.exp_idx   = i;
    t.exp_ovr   = o;
    vecs.push_back(t);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    en      = 1'b0;
    req     = 8'h00;
    ready   = 1'b0;
    reset_n = 1'b0;

    // Two requests in one cycle drain on consecutive cycles.
    add(1, 1, 8'h24, 1, 0, 3'd0, 0);
    add(0, 1, 8'h00, 1, 1, 3'd2, 0);
    add(0, 1, 8'h00, 1, 1, 3'd5, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0);
    // Backpressure: idx holds while ready is low, then the other bit follows.
    add(1, 1, 8'h81, 0, 0, 3'd0, 0);
    add(0, 1, 8'h00, 0, 1, 3'd0, 0);
    add(0, 1, 8'h00, 0, 1, 3'd0, 0);
    add(0, 1, 8'h00, 0, 1, 3'd0, 0);
    add(0, 1, 8'h00, 0, 1, 3'd0, 0);
    add(0, 1, 8'h00, 0, 1, 3'd0, 0);
    add(0, 1, 8'h00, 1, 1, 3'd7, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0);
    // Overrun on a repeated pending bit; en=0 blocks capture and overrun.
    add(1, 1, 8'h08, 0, 0, 3'd0, 0);
    add(0, 1, 8'h08, 0, 1, 3'd3, 1);
    add(0, 1, 8'h00, 1, 0, 3'd0, 1);
    add(0, 0, 8'hFF, 1, 0, 3'd0, 1);
    add(0, 0, 8'hFF, 1, 0, 3'd0, 1);
    add(0, 0, 8'h00, 1, 0, 3'd0, 1);
    // Full burst drains at one index per cycle.
    add(1, 1, 8'hFF, 1, 0, 3'd0, 0);
    add(0, 1, 8'h00, 1, 1, 3'd0, 0);
    add(0, 1, 8'h00, 1, 1, 3'd1, 0);
    add(0, 1, 8'h00, 1, 1, 3'd2, 0);
    add(0, 1, 8'h00, 1, 1, 3'd3, 0);
    add(0, 1, 8'h00, 1, 1, 3'd4, 0);
    add(0, 1, 8'h00, 1, 1, 3'd5, 0);
    add(0, 1, 8'h00, 1, 1, 3'd6, 0);
    add(0, 1, 8'h00, 1, 1, 3'd7, 0);
    add(0, 1, 8'h00, 1, 0, 3'd0, 0);

    do_reset();
    expect_out("reset", 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].en, vecs[i].req, vecs[i].ready);
      expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_ovr);
    end

    // Asynchronous reset mid-stream with everything pending and overrun set.
    do_reset();
    step(1, 8'hFF, 0);
    step(1, 8'hFF, 0);
    expect_out("arst pre", 1'b1, 3'd0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("arst async", 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h00, 1);
      expect_out($sformatf("arst post%0d", i), 1'b0, 3'd0, 1'b0);
    end

    // Re-request of the bit granted on the same edge is a new event, not an overrun.
    do_reset();
    step(1, 8'h05, 0);
    expect_out("rereq load", 1'b0, 3'd0, 1'b0);
    step(1, 8'h00, 0);
    expect_out("rereq first", 1'b1, 3'd0, 1'b0);
    step(1, 8'h01, 1);
    expect_out("rereq second", 1'b1, 3'd2, 1'b0);
    step(1, 8'h00, 1);
    expect_out("rereq third", 1'b1, 3'd0, 1'b0);
    step(1, 8'h00, 1);
    expect_out("rereq empty", 1'b0, 3'd0, 1'b0);

    // Selection order after a grant of index 2 with bits 1 and 4 pending.
    do_reset();
    step(1, 8'h04, 1);
    step(1, 8'h00, 1);
    expect_out("order g2", 1'b1, 3'd2, 1'b0);
    step(1, 8'h12, 1);
    expect_out("order gap", 1'b0, 3'd0, 1'b0);
`ifdef REQ_ENC_ROUND_ROBIN_EN
    step(1, 8'h00, 1);
    expect_out("order a", 1'b1, 3'd4, 1'b0);
    step(1, 8'h00, 1);
    expect_out("order b", 1'b1, 3'd1, 1'b0);
`else
    step(1, 8'h00, 1);
    expect_out("order a", 1'b1, 3'd1, 1'b0);
    step(1, 8'h00, 1);
    expect_out("order b", 1'b1, 3'd4, 1'b0);
`endif
    step(1, 8'h00, 1);
    expect_out("order end", 1'b0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
